idmem_bus_bridge: RTL
=====================

// Module: idmem_bus_bridge
// PURPOSE
//  Sits between the multicycle datapath's single memory port and an external variable-latency
//  memory bus; replaces the zero-wait synchronous RAM in the multicycle core.
//  Turns the core's one-cycle read/write strobe into a REQ/GNT + RVALID transaction.
//  Holds the core with STALL until the access completes, then presents read data for one cycle.
//  Flags misaligned accesses and memory timeouts on ERR.
// PARAMETERS
//  AW       32   address width (byte address; word-aligned accesses only)
//  DW       32   data width
//  TIMEOUT  255  max cycles in WAIT before abort; counter is $clog2(TIMEOUT+1) bits
// PORTS
//  CLK        in   1   clock, rising edge
//  RST_N      in   1   asynchronous, active-low reset
//  CPU_REQ    in   1   core access request; sampled in IDLE only
//  CPU_WE     in   1   1=write, 0=read; qualified by CPU_REQ
//  CPU_A      in   AW  byte address
//  CPU_WD     in   DW  write data
//  CPU_RD     out  DW  read data; valid while CPU_DONE=1
//  CPU_DONE   out  1   one-cycle completion pulse
//  CPU_STALL  out  1   core must hold all state while 1
//  CPU_ERR    out  1   one-cycle pulse with CPU_DONE: misaligned or timeout
//  MEM_REQ    out  1   bus request; held until MEM_GNT
//  MEM_WE     out  1   bus write enable
//  MEM_ADDR   out  AW  bus address (registered)
//  MEM_WDATA  out  DW  bus write data (registered)
//  MEM_GNT    in   1   bus accepts the request this cycle
//  MEM_RVALID in   1   read data valid
//  MEM_RDATA  in   DW  read data
// BEHAVIOUR
//  Reset (RST_N=0, async): state=IDLE; MEM_REQ=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0,
//   CPU_RD=0, CPU_DONE=0, CPU_ERR=0, timer=0. CPU_STALL is combinational (1 with CPU_REQ in IDLE, else 0).
//  A reset during a transaction aborts it: MEM_REQ drops immediately; a later RVALID/GNT is ignored.
//  FSM states: IDLE, ADDR, WAIT, DONE.
//   IDLE: CPU_REQ=1 and CPU_A[1:0]==0 -> latch A/WD/WE into MEM_*; go to ADDR.
//         CPU_REQ=1 and CPU_A[1:0]!=0 -> no bus access; go to DONE with ERR=1, RD=0.
//   ADDR: MEM_REQ=1. No GNT -> stay. GNT & write -> DONE. GNT & read & RVALID -> DONE
//         (capture RDATA). GNT & read & !RVALID -> WAIT.
//   WAIT: MEM_REQ=0; timer counts up from 0 each cycle. RVALID -> capture RDATA; go to DONE.
//         timer==TIMEOUT without RVALID -> DONE with ERR=1, RD=0.
//   DONE: CPU_DONE=1 for exactly one cycle, CPU_RD/CPU_ERR valid; always go to IDLE.
//  No timeout in ADDR: the bus owns arbitration, so GNT may be withheld indefinitely.
//  CPU_STALL = (state==ADDR)|(state==WAIT)|(state==IDLE & CPU_REQ). It is 0 in DONE.
//  The core must drop or advance CPU_REQ in the DONE cycle; CPU_REQ in DONE is ignored.
//  Min latency: read with RVALID at GNT = 3 cycles CPU_REQ->CPU_DONE (IDLE,ADDR,DONE).
//  A write needs GNT in the first ADDR cycle to meet the same 3 cycles.
//  MEM_RVALID in IDLE/ADDR-without-GNT/DONE: ignored.
//  MEM_ADDR/MEM_WDATA/MEM_WE stay stable from ADDR entry until the next IDLE accept.
//  CPU_RD holds its last value outside DONE; only the DONE cycle is guaranteed.
// STRUCTURE
//  Shared package bridge_pkg: typedef enum logic [1:0] {IDLE,ADDR,WAIT,DONE} bridge_state_t;
//   localparam ERR_RDATA = '0.
//  Sub-module wait_timer (clear, enable, TIMEOUT param, expired out) implements the WAIT counter.
//   wait_timer is cleared on ADDR->WAIT.
//  Everything else (FSM, holding registers) is in this module.
// TESTING
//  Read, GNT+RVALID same cycle, RDATA=32'h1234_5678 -> DONE at cycle 3, RD=32'h1234_5678, ERR=0.
//  Write A=32'h40, WD=32'hCAFE_F00D; GNT withheld 5 cycles -> MEM_REQ high 6 cycles.
//   Expect MEM_ADDR=32'h40 held, STALL=1 throughout, one DONE pulse.
//  Read with RVALID 10 cycles after GNT, TIMEOUT=255 -> WAIT 10 cycles, RD captured, no ERR.
//  Read, RVALID never arrives, TIMEOUT=8 -> DONE+ERR after 9 WAIT cycles, RD=0, back to IDLE.
//  CPU_A=32'h42 -> no MEM_REQ, DONE+ERR next cycle after IDLE, RD=0.
//  RST_N low during WAIT, then RVALID pulse -> MEM_REQ=0 immediately, no DONE, state IDLE.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and constants for the core-to-memory-bus bridge.
package bridge_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } bridge_state_t;

    // Read data returned on a misaligned or timed-out access.
    localparam logic [63:0] ERR_RDATA = '0;

    function automatic logic is_word_aligned(input logic [1:0] lsb);
        return (lsb == 2'b00);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// Cycle counter for the read-data wait phase; flags when the allowed wait is used up.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(TIMEOUT));

    // Holds at TIMEOUT so a late enable can never wrap back to zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            r_cnt <= '0;
        else if (i_clear)
            r_cnt <= '0;
        else if (i_enable && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/idmem_bus_bridge.sv
// Converts the multicycle core's single-cycle memory strobe into a REQ/GNT + RVALID bus
// transaction, stalling the core until completion and flagging misalignment/timeouts.
module idmem_bus_bridge
    import bridge_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_cpu_req,
    input  logic          i_cpu_we,
    input  logic [AW-1:0] i_cpu_a,
    input  logic [DW-1:0] i_cpu_wd,
    output logic [DW-1:0] o_cpu_rd,
    output logic          o_cpu_done,
    output logic          o_cpu_stall,
    output logic          o_cpu_err,
    output logic          o_mem_req,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [DW-1:0] o_mem_wdata,
    input  logic          i_mem_gnt,
    input  logic          i_mem_rvalid,
    input  logic [DW-1:0] i_mem_rdata
);
    bridge_state_t r_state;
    logic          r_mem_req;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic [DW-1:0] r_rd;
    logic          r_err;

    logic w_tmr_clear;
    logic w_tmr_en;
    logic w_tmr_expired;

    // Timer restarts on every granted read that still has to wait for data.
    assign w_tmr_clear = (r_state == ADDR) && i_mem_gnt && !r_mem_we && !i_mem_rvalid;
    assign w_tmr_en    = (r_state == WAIT);

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_clear   (w_tmr_clear),
        .i_enable  (w_tmr_en),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_rd        <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_cpu_req) begin
                        if (is_word_aligned(i_cpu_a[1:0])) begin
                            r_mem_addr  <= i_cpu_a;
                            r_mem_wdata <= i_cpu_wd;
                            r_mem_we    <= i_cpu_we;
                            r_mem_req   <= 1'b1;
                            r_state     <= ADDR;
                        end else begin
                            r_rd    <= DW'(ERR_RDATA);
                            r_err   <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                ADDR: begin
                    if (i_mem_gnt) begin
                        r_mem_req <= 1'b0;
                        if (r_mem_we) begin
                            r_err   <= 1'b0;
                            r_state <= DONE;
                        end else if (i_mem_rvalid) begin
                            r_rd    <= i_mem_rdata;
                            r_err   <= 1'b0;
                            r_state <= DONE;
                        end else begin
                            r_state <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    // Data arriving on the final allowed cycle still wins over the timeout.
                    if (i_mem_rvalid) begin
                        r_rd    <= i_mem_rdata;
                        r_err   <= 1'b0;
                        r_state <= DONE;
                    end else if (w_tmr_expired) begin
                        r_rd    <= DW'(ERR_RDATA);
                        r_err   <= 1'b1;
                        r_state <= DONE;
                    end
                end
                DONE: begin
                    r_err   <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_cpu_rd    = r_rd;
    assign o_cpu_done  = (r_state == DONE);
    assign o_cpu_err   = r_err;
    assign o_cpu_stall = (r_state == ADDR) || (r_state == WAIT) ||
                         ((r_state == IDLE) && i_cpu_req);
    assign o_mem_req   = r_mem_req;
    assign o_mem_we    = r_mem_we;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;

endmodule
